// File: rtl/power_domain_sequencer.sv
// Power-up/power-down sequencer for N_DOM switchable domains: one shared FSM walks
// a single domain at a time through switch enable, settle, reset and isolation steps.
module power_domain_sequencer #(
  parameter int N_DOM   = 4,
  parameter int ISO_DLY = 4,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DOM-1:0] pwr_req,
  input  logic [N_DOM-1:0] sw_ack,
  output logic [N_DOM-1:0] sw_en,
  output logic [N_DOM-1:0] iso_en,
  output logic [N_DOM-1:0] dom_rst,
  output logic [N_DOM-1:0] pwr_ack,
  output logic [N_DOM-1:0] pwr_err,
  output logic             busy,
  output logic [2:0]       state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] UP_SW     = 3'd1;
  localparam logic [2:0] UP_SETTLE = 3'd2;
  localparam logic [2:0] UP_ISO    = 3'd3;
  localparam logic [2:0] DN_ISO    = 3'd4;
  localparam logic [2:0] DN_SW     = 3'd5;

  localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [15:0] ISO_LAST    = 16'(ISO_DLY - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);

  logic [15:0]   cnt;
  logic [IW-1:0] cur;
  logic          found;
  logic [IW-1:0] sel;

  // Lowest-index domain whose request differs from its ack; failed domains are skipped.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int d = N_DOM - 1; d >= 0; d--) begin
      if ((pwr_req[d] != pwr_ack[d]) && !pwr_err[d]) begin
        found = 1'b1;
        sel   = IW'(d);
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur     <= '0;
      sw_en   <= '0;
      iso_en  <= '1;
      dom_rst <= '1;
      pwr_ack <= '0;
      pwr_err <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A dropped request is the only way to acknowledge a switch failure.
          pwr_err <= pwr_err & pwr_req;
          if (found) begin
            cur <= sel;
            cnt <= '0;
            if (pwr_req[sel]) begin
              sw_en[sel] <= 1'b1;
              state      <= UP_SW;
            end else begin
              iso_en[sel] <= 1'b1;
              state       <= DN_ISO;
            end
          end
        end
        UP_SW: begin
          if (sw_ack[cur]) begin
            cnt   <= '0;
            state <= UP_SETTLE;
          end else if (cnt == TO_LAST) begin
            // Rail never came up: drop the switch, keep the domain isolated and in reset.
            sw_en[cur]   <= 1'b0;
            pwr_err[cur] <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        UP_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            dom_rst[cur] <= 1'b0;
            cnt          <= '0;
            state        <= UP_ISO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        UP_ISO: begin
          if (cnt == ISO_LAST) begin
            iso_en[cur]  <= 1'b0;
            pwr_ack[cur] <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DN_ISO: begin
          if (cnt == ISO_LAST) begin
            dom_rst[cur] <= 1'b1;
            sw_en[cur]   <= 1'b0;
            cnt          <= '0;
            state        <= DN_SW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DN_SW: begin
          if (!sw_ack[cur]) begin
            pwr_ack[cur] <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
          end else if (cnt == TO_LAST) begin
            pwr_err[cur] <= 1'b1;
            pwr_ack[cur] <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer with default parameters; expected
// cycle positions are worked out by hand from the sequencing rules.
module tb_power_domain_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] pwr_req;
  logic [3:0] sw_ack;
  logic [3:0] sw_en;
  logic [3:0] iso_en;
  logic [3:0] dom_rst;
  logic [3:0] pwr_ack;
  logic [3:0] pwr_err;
  logic       busy;
  logic [2:0] state;

  int checks;
  int failures;

  power_domain_sequencer #(
    .N_DOM(4), .ISO_DLY(4), .SETTLE(8), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .pwr_req(pwr_req), .sw_ack(sw_ack),
    .sw_en(sw_en), .iso_en(iso_en), .dom_rst(dom_rst), .pwr_ack(pwr_ack),
    .pwr_err(pwr_err), .busy(busy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    pwr_req = 4'b0000;
    sw_ack  = 4'b0000;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sw_en !== 4'b0000) begin failures++; $display("FAIL rst_async_sw_en got=%b exp=0000", sw_en); end
    checks++; if (iso_en !== 4'b1111) begin failures++; $display("FAIL rst_async_iso_en got=%b exp=1111", iso_en); end
    checks++; if (dom_rst !== 4'b1111) begin failures++; $display("FAIL rst_async_dom_rst got=%b exp=1111", dom_rst); end
    step(3);
    checks++; if (pwr_ack !== 4'b0000 || pwr_err !== 4'b0000) begin failures++; $display("FAIL rst_held_ack_err got=%b/%b exp=0000/0000", pwr_ack, pwr_err); end
    checks++; if (busy !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL rst_held_busy_state got=%b/%0d exp=0/0", busy, state); end
    checks++; if (sw_en !== 4'b0000) begin failures++; $display("FAIL rst_held_sw_en got=%b exp=0000", sw_en); end
    pwr_req = 4'b0000;
    reset   = 1'b0;
    step(2);
    checks++; if (busy !== 1'b0 || sw_en !== 4'b0000) begin failures++; $display("FAIL rst_idle_after got busy=%b sw_en=%b exp 0/0000", busy, sw_en); end
  endtask

  task automatic test_power_up();
    pwr_req = 4'b0001;
    step(1);
    checks++; if (sw_en !== 4'b0001) begin failures++; $display("FAIL up_sw_en got=%b exp=0001", sw_en); end
    checks++; if (busy !== 1'b1 || state !== 3'd1) begin failures++; $display("FAIL up_state got=%b/%0d exp=1/1", busy, state); end
    step(2);
    sw_ack = 4'b0001;
    step(8);
    checks++; if (dom_rst !== 4'b1111) begin failures++; $display("FAIL up_rst_early got=%b exp=1111", dom_rst); end
    step(1);
    checks++; if (dom_rst !== 4'b1110) begin failures++; $display("FAIL up_rst_release got=%b exp=1110", dom_rst); end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL up_iso_state got=%0d exp=3", state); end
    step(3);
    checks++; if (iso_en !== 4'b1111 || pwr_ack !== 4'b0000) begin failures++; $display("FAIL up_iso_early got=%b/%b exp=1111/0000", iso_en, pwr_ack); end
    step(1);
    checks++; if (iso_en !== 4'b1110) begin failures++; $display("FAIL up_iso_release got=%b exp=1110", iso_en); end
    checks++; if (pwr_ack !== 4'b0001 || sw_en !== 4'b0001) begin failures++; $display("FAIL up_done got ack=%b sw_en=%b exp 0001/0001", pwr_ack, sw_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_busy_low got=%b exp=0", busy); end
  endtask

  task automatic test_power_down();
    pwr_req = 4'b0000;
    step(1);
    checks++; if (iso_en !== 4'b1111 || state !== 3'd4) begin failures++; $display("FAIL dn_iso got=%b/%0d exp=1111/4", iso_en, state); end
    checks++; if (pwr_ack !== 4'b0001) begin failures++; $display("FAIL dn_ack_held got=%b exp=0001", pwr_ack); end
    step(3);
    checks++; if (dom_rst !== 4'b1110 || sw_en !== 4'b0001) begin failures++; $display("FAIL dn_early got=%b/%b exp=1110/0001", dom_rst, sw_en); end
    step(1);
    checks++; if (dom_rst !== 4'b1111 || sw_en !== 4'b0000) begin failures++; $display("FAIL dn_switch_off got=%b/%b exp=1111/0000", dom_rst, sw_en); end
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL dn_sw_state got=%0d exp=5", state); end
    step(2);
    checks++; if (pwr_ack !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL dn_wait_ack got=%b/%b exp=0001/1", pwr_ack, busy); end
    sw_ack = 4'b0000;
    step(1);
    checks++; if (pwr_ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL dn_done got=%b/%b exp=0000/0", pwr_ack, busy); end
  endtask

  task automatic test_sequential_domains();
    pwr_req = 4'b0110;
    step(1);
    checks++; if (sw_en !== 4'b0010 || state !== 3'd1) begin failures++; $display("FAIL seq_first got=%b/%0d exp=0010/1", sw_en, state); end
    sw_ack = 4'b0010;
    step(12);
    checks++; if (pwr_ack !== 4'b0000 || sw_en !== 4'b0010) begin failures++; $display("FAIL seq_d1_pending got=%b/%b exp=0000/0010", pwr_ack, sw_en); end
    step(1);
    checks++; if (pwr_ack !== 4'b0010 || sw_en !== 4'b0010 || busy !== 1'b0) begin failures++; $display("FAIL seq_idle_gap got=%b/%b/%b exp=0010/0010/0", pwr_ack, sw_en, busy); end
    step(1);
    checks++; if (sw_en !== 4'b0110 || state !== 3'd1) begin failures++; $display("FAIL seq_second got=%b/%0d exp=0110/1", sw_en, state); end
    sw_ack = 4'b0110;
    step(13);
    checks++; if (pwr_ack !== 4'b0110 || iso_en !== 4'b1001 || dom_rst !== 4'b1001) begin failures++; $display("FAIL seq_done got=%b/%b/%b exp=0110/1001/1001", pwr_ack, iso_en, dom_rst); end
  endtask

  task automatic test_timeout();
    pwr_req = 4'b1110;
    step(1);
    checks++; if (sw_en !== 4'b1110) begin failures++; $display("FAIL to_start got=%b exp=1110", sw_en); end
    step(254);
    checks++; if (sw_en !== 4'b1110 || busy !== 1'b1 || pwr_err !== 4'b0000) begin failures++; $display("FAIL to_early got=%b/%b/%b exp=1110/1/0000", sw_en, busy, pwr_err); end
    step(1);
    checks++; if (sw_en !== 4'b0110 || pwr_err !== 4'b1000) begin failures++; $display("FAIL to_fire got=%b/%b exp=0110/1000", sw_en, pwr_err); end
    checks++; if (iso_en !== 4'b1001 || dom_rst !== 4'b1001 || pwr_ack !== 4'b0110 || busy !== 1'b0) begin failures++; $display("FAIL to_outputs got=%b/%b/%b/%b exp=1001/1001/0110/0", iso_en, dom_rst, pwr_ack, busy); end
    step(5);
    checks++; if (sw_en !== 4'b0110 || busy !== 1'b0 || pwr_err !== 4'b1000) begin failures++; $display("FAIL to_no_retry got=%b/%b/%b exp=0110/0/1000", sw_en, busy, pwr_err); end
    pwr_req = 4'b0110;
    step(1);
    checks++; if (pwr_err !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b/%b exp=0000/0", pwr_err, busy); end
  endtask

  task automatic test_reset_mid_sequence();
    apply_reset();
    pwr_req = 4'b0001;
    step(1);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rm_up_sw got=%0d exp=1", state); end
    sw_ack = 4'b0001;
    step(3);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL rm_settle got=%0d exp=2", state); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (sw_en !== 4'b0000 || iso_en !== 4'b1111 || dom_rst !== 4'b1111) begin failures++; $display("FAIL rm_async got=%b/%b/%b exp=0000/1111/1111", sw_en, iso_en, dom_rst); end
    checks++; if (pwr_ack !== 4'b0000 || busy !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL rm_async_state got=%b/%b/%0d exp=0000/0/0", pwr_ack, busy, state); end
    sw_ack = 4'b0000;
    step(2);
    reset = 1'b0;
    step(1);
    checks++; if (state !== 3'd1 || sw_en !== 4'b0001) begin failures++; $display("FAIL rm_restart got=%0d/%b exp=1/0001", state, sw_en); end
    sw_ack = 4'b0001;
    step(13);
    checks++; if (pwr_ack !== 4'b0001 || busy !== 1'b0) begin failures++; $display("FAIL rm_complete got=%b/%b exp=0001/0", pwr_ack, busy); end
  endtask

  task automatic test_req_change_during_seq();
    apply_reset();
    pwr_req = 4'b0001;
    step(1);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rc_up_sw got=%0d exp=1", state); end
    pwr_req = 4'b0000;
    step(2);
    checks++; if (state !== 3'd1 || sw_en !== 4'b0001) begin failures++; $display("FAIL rc_ignored got=%0d/%b exp=1/0001", state, sw_en); end
    sw_ack = 4'b0001;
    step(12);
    checks++; if (pwr_ack !== 4'b0000) begin failures++; $display("FAIL rc_early got=%b exp=0000", pwr_ack); end
    step(1);
    checks++; if (pwr_ack !== 4'b0001 || iso_en !== 4'b1110 || busy !== 1'b0) begin failures++; $display("FAIL rc_up_done got=%b/%b/%b exp=0001/1110/0", pwr_ack, iso_en, busy); end
    step(1);
    checks++; if (state !== 3'd4 || iso_en !== 4'b1111) begin failures++; $display("FAIL rc_down_start got=%0d/%b exp=4/1111", state, iso_en); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    pwr_req  = 4'b1111;
    sw_ack   = 4'b0000;
    test_reset();
    test_power_up();
    test_power_down();
    test_sequential_domains();
    test_timeout();
    test_reset_mid_sequence();
    test_req_change_during_seq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
